// File: rtl/fft_pkg.sv
// Shared FFT constants, complex sample payload and collector state encoding.
package fft_pkg;

    localparam int unsigned DW     = 20;
    localparam int unsigned LANES  = 8;
    localparam int unsigned NPTS   = 256;
    localparam int unsigned BEATS  = NPTS / LANES;
    localparam int unsigned BEAT_W = $clog2(BEATS);
    localparam int unsigned IDX_W  = $clog2(NPTS);

    // Complex sample: real part in the upper half.
    typedef struct packed {
        logic [DW-1:0] re;
        logic [DW-1:0] im;
    } cplx_t;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } coll_state_t;

endpackage

// File: rtl/fft_bitrev.sv
// Combinational W-bit bit-reversal of an address.
module fft_bitrev #(
    parameter int unsigned W = 8
) (
    input  logic [W-1:0] i_addr,
    output logic [W-1:0] o_addr
);

    // Mirror bit b onto bit W-1-b.
    for (genvar b = 0; b < W; b++) begin : g_bit
        assign o_addr[b] = i_addr[W-1-b];
    end

endmodule

// File: rtl/descrambler_collector.sv
// Single-buffer collector: fills NPTS samples from LANES-wide beats, then
// drains them one per transfer in index order.
// Optional build macro DESCRAMBLER_BITREV_EN: write addresses are bit-reversed
// so a bit-reversed-order FFT result drains in natural order.
module descrambler_collector #(
    parameter int unsigned DW    = fft_pkg::DW,
    parameter int unsigned LANES = fft_pkg::LANES,
    parameter int unsigned NPTS  = fft_pkg::NPTS
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*2*DW-1:0]   in_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [2*DW-1:0]         out_data,
    output logic [7:0]              out_idx,
    output logic                    frame_done
);

    import fft_pkg::*;

    localparam int unsigned SW      = 2 * DW;
    localparam int unsigned NBEATS  = NPTS / LANES;
    localparam int unsigned NBEAT_W = (NBEATS > 1) ? $clog2(NBEATS) : 1;
    localparam int unsigned OIDX_W  = 8;

    coll_state_t        r_state;
    coll_state_t        w_state_nxt;
    logic [NBEAT_W-1:0] r_beat;
    logic [OIDX_W-1:0]  r_idx;
    logic               r_frame_done;
    logic [SW-1:0]      r_mem [NPTS];

    logic               w_accept;
    logic               w_xfer;
    logic               w_last_beat;
    logic               w_last_idx;
    logic [OIDX_W-1:0]  w_waddr [LANES];

    assign w_last_beat = (r_beat == NBEAT_W'(NBEATS - 1));
    assign w_last_idx  = (r_idx == OIDX_W'(NPTS - 1));

    // Next-state and handshake decode.
    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_xfer      = 1'b0;
        case (r_state)
            ST_FILL: begin
                w_accept = in_valid;
                if (in_valid && w_last_beat) begin
                    w_state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                w_xfer = out_ready;
                if (out_ready && w_last_idx) begin
                    w_state_nxt = ST_FILL;
                end
            end
            default: w_state_nxt = ST_FILL;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Beat counter, drain index and end-of-frame pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_beat       <= '0;
            r_idx        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_frame_done <= w_xfer && w_last_idx;
            if (w_accept) begin
                r_beat <= w_last_beat ? '0 : r_beat + NBEAT_W'(1);
            end
            if (w_xfer) begin
                r_idx <= w_last_idx ? '0 : r_idx + OIDX_W'(1);
            end
        end
    end

    // Per-lane write address: linear position, optionally bit-reversed.
    for (genvar k = 0; k < LANES; k++) begin : g_lane
        logic [OIDX_W-1:0] w_lin;
        assign w_lin = OIDX_W'(r_beat * LANES + k);
`ifdef DESCRAMBLER_BITREV_EN
        fft_bitrev #(
            .W (OIDX_W)
        ) u_bitrev (
            .i_addr (w_lin),
            .o_addr (w_waddr[k])
        );
`else
        assign w_waddr[k] = w_lin;
`endif
    end

    // Sample storage: all lanes of an accepted beat written together, no reset.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            for (int k = 0; k < LANES; k++) begin
                r_mem[w_waddr[k]] <= in_data[k*SW +: SW];
            end
        end
    end

    assign in_ready   = (r_state == ST_FILL);
    assign out_valid  = (r_state == ST_DRAIN);
    assign out_data   = (r_state == ST_DRAIN) ? r_mem[r_idx] : '0;
    assign out_idx    = r_idx;
    assign frame_done = r_frame_done;

endmodule

// File: tb/tb_descrambler_collector.sv
// Scoreboard bench for descrambler_collector; honours DESCRAMBLER_BITREV_EN.
module tb_descrambler_collector;

    import fft_pkg::*;

    localparam int SW = 2 * DW;
    localparam int NB = NPTS / LANES;

    typedef struct {
        int            idx;
        logic [SW-1:0] data;
    } exp_t;

    logic                  clk = 1'b0;
    logic                  rst_n = 1'b0;
    logic                  in_valid = 1'b0;
    logic                  in_ready;
    logic [LANES*SW-1:0]   in_data = '0;
    logic                  out_valid;
    logic                  out_ready = 1'b0;
    logic [SW-1:0]         out_data;
    logic [7:0]            out_idx;
    logic                  frame_done;

    exp_t          sbq[$];
    logic [SW-1:0] arrival [NPTS];
    int            acc_cnt = 0;
    bit            vflag = 0;
    bit            exp_fd = 0;
    bit            prev_stall = 0;
    logic [SW-1:0] prev_data;
    logic [7:0]    prev_idx;
    int            n_tests = 0;
    int            n_fail = 0;
    int            ready_pct = 100;

    descrambler_collector dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_idx    (out_idx),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    function automatic void chk(string name, logic [63:0] act, logic [63:0] req);
        n_tests++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endfunction

    function automatic int bitrev8(int v);
        int r = 0;
        for (int b = 0; b < 8; b++) begin
            if (((v >> b) & 1) != 0) r |= (1 << (7 - b));
        end
        return r;
    endfunction

    // Which arrival position ends up at drain index i.
    function automatic int src_of(int i);
`ifdef DESCRAMBLER_BITREV_EN
        return bitrev8(i);
`else
        return i;
`endif
    endfunction

    // Downstream backpressure.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            out_ready = ($urandom_range(99) < ready_pct);
        end
    end

    // Monitor: output checks, then input capture into the reference model.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            prev_stall = 0;
            exp_fd     = 0;
            vflag      = 0;
            acc_cnt    = 0;
        end else begin
            chk("frame_done", frame_done, exp_fd);
            if (exp_fd) chk("in_ready_after_frame", in_ready, 1);
            exp_fd = 0;
            chk("ready_valid_excl", in_ready, !out_valid);
            if (vflag) chk("out_valid_after_last_beat", out_valid, 1);
            vflag = 0;
            if (!out_valid) begin
                chk("out_data_idle_zero", out_data, 0);
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    chk("stall_data_stable", out_data, prev_data);
                    chk("stall_idx_stable", out_idx, prev_idx);
                end
                if (out_ready) begin
                    if (sbq.size() == 0) begin
                        chk("unexpected_sample", out_idx, 9'h100);
                    end else begin
                        e = sbq.pop_front();
                        chk("out_idx", out_idx, e.idx);
                        chk("out_data", out_data, e.data);
                        if (e.idx == NPTS - 1) exp_fd = 1;
                    end
                end
                prev_stall = !out_ready;
                prev_data  = out_data;
                prev_idx   = out_idx;
            end
            if (in_valid && in_ready) begin
                for (int k = 0; k < LANES; k++) begin
                    arrival[acc_cnt*LANES + k] = in_data[k*SW +: SW];
                end
                acc_cnt++;
                if (acc_cnt == NB) begin
                    for (int i = 0; i < NPTS; i++) begin
                        e.idx  = i;
                        e.data = arrival[src_of(i)];
                        sbq.push_back(e);
                    end
                    acc_cnt = 0;
                    vflag   = 1;
                end
            end
        end
    end

    task automatic drive_beat(int c, bit directed);
        cplx_t s;
        for (int k = 0; k < LANES; k++) begin
            if (directed) begin
                s.re = DW'(c * LANES + k);
                s.im = ~DW'(c * LANES + k);
            end else begin
                s.re = DW'($urandom);
                s.im = DW'($urandom);
            end
            in_data[k*SW +: SW] = s;
        end
    endtask

    task automatic send_frame(int nbeats, bit directed, int gap_pct);
        for (int c = 0; c < nbeats; c++) begin
            int g = 0;
            int w = 0;
            bit acc;
            while (g < 4 && $urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                @(posedge clk);
                #1;
                g++;
            end
            drive_beat(c, directed);
            in_valid = 1'b1;
            do begin
                acc = in_ready;
                @(posedge clk);
                #1;
                w++;
            end while (!acc && w < 2000);
            if (!acc) chk("beat_accept_timeout", acc, 1);
        end
        in_valid = 1'b0;
    endtask

    // Keep presenting changing beats while the collector drains.
    task automatic junk_through_drain();
        int w = 0;
        while (!in_ready && w < 3000) begin
            in_valid = 1'b1;
            drive_beat(0, 1'b0);
            @(posedge clk);
            #1;
            w++;
        end
        in_valid = 1'b0;
        chk("junk_drain_timeout", in_ready, 1);
    endtask

    task automatic wait_done();
        int w = 0;
        while (!(in_ready && sbq.size() == 0) && w < 5000) begin
            @(posedge clk);
            #1;
            w++;
        end
        chk("drain_done_timeout", (in_ready && sbq.size() == 0), 1);
    endtask

    task automatic do_reset();
        rst_n    = 1'b0;
        in_valid = 1'b0;
        sbq.delete();
        acc_cnt  = 0;
        vflag    = 0;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_idx", out_idx, 0);
        chk("rst_frame_done", frame_done, 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        int w;
        do_reset();

        // Directed ramp frame, full throughput downstream.
        ready_pct = 100;
        send_frame(NB, 1'b1, 0);
        wait_done();

        // Random frame with 50% backpressure.
        ready_pct = 50;
        send_frame(NB, 1'b0, 0);
        wait_done();

        // Continuous in_valid with changing data during drain.
        send_frame(NB, 1'b0, 0);
        junk_through_drain();
        wait_done();

        // Reset after beat 17, then a clean frame.
        send_frame(18, 1'b0, 20);
        do_reset();
        send_frame(NB, 1'b1, 20);
        wait_done();

        // Reset mid-drain at index 100, then a clean frame.
        send_frame(NB, 1'b0, 0);
        w = 0;
        do begin
            @(negedge clk);
            w++;
        end while (!(out_valid && out_idx == 8'd100) && w < 3000);
        chk("reach_idx100_timeout", (out_valid && out_idx == 8'd100), 1);
        #2;
        do_reset();
        send_frame(NB, 1'b0, 0);
        wait_done();

        // Two back-to-back frames with random input gaps.
        send_frame(NB, 1'b0, 40);
        send_frame(NB, 1'b0, 40);
        wait_done();

        repeat (3) @(posedge clk);
        chk("scoreboard_empty", sbq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/descrambler_collector.md
DESCRAMBLER_COLLECTOR -- requirements
Module: descrambler_collector

Interface
REQ-001 SHALL have parameter DW, 20, width of each real and each imaginary component.
REQ-002 SHALL have parameter LANES, 8, complex samples per input beat.
REQ-003 SHALL have parameter NPTS, 256, samples per frame; beats per frame = NPTS/LANES = 32.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have port in_valid, input, 1, input beat valid.
REQ-007 SHALL have port in_ready, output, 1, collector can accept a beat.
REQ-008 SHALL have port in_data, input, LANES*2*DW, lane k at bits [k*2*DW +: 2*DW]; each lane is {re[DW-1:0], im[DW-1:0]}, re in the upper half.
REQ-009 SHALL have port out_valid, output, 1, output sample valid.
REQ-010 SHALL have port out_ready, input, 1, downstream accepts a sample.
REQ-011 SHALL have port out_data, output, 2*DW, {re, im} of the current sample.
REQ-012 SHALL have port out_idx, output, 8, frequency index of the current sample, 0..255.
REQ-013 SHALL have port frame_done, output, 1, one-cycle pulse after the last sample of a frame transfers.

Function
REQ-014 SHALL implement two states, FILL and DRAIN, with NPTS x 2*DW sample storage.
- in_ready = 1 exactly when the state is FILL.
- out_valid = 1 exactly when the state is DRAIN.
REQ-015 In FILL, a beat SHALL be accepted on a cycle where in_valid && in_ready.
- Beat counter c (5 bits, 0..31) increments on each accepted beat.
- Lane k is written to address a = 8*c + k.
REQ-016 On acceptance of beat c = 31, c SHALL wrap to 0 and the state SHALL become DRAIN on the next edge.
- out_valid rises one cycle after the 32nd accepted beat.
REQ-017 In DRAIN, out_data SHALL equal storage[out_idx] combinationally; out_data SHALL be 0 whenever out_valid = 0.
REQ-018 A sample SHALL transfer when out_valid && out_ready; out_idx then increments by 1.
REQ-019 While out_valid && !out_ready, out_data and out_idx SHALL hold stable.
REQ-020 On transfer of out_idx = 255:
- out_idx wraps to 0.
- The state returns to FILL on the next edge.
- frame_done pulses high for exactly that next cycle.
REQ-021 in_valid in DRAIN SHALL be ignored: no write and no counter change. No input beat is lost, because in_ready = 0 in DRAIN.
REQ-022 out_ready in FILL SHALL be ignored.
REQ-023 There SHALL be no overlap of fill and drain (single buffer). Frame throughput is 32 input cycles + 256 output cycles minimum.

Reset
REQ-024 While rst_n = 0, the block SHALL hold: state FILL, c = 0, out_idx = 0, in_ready = 1, out_valid = 0, out_data = 0, frame_done = 0.
REQ-025 Storage contents SHALL NOT be reset.
REQ-026 Reset asserted mid-FILL or mid-DRAIN SHALL abort the frame. The next frame starts at beat 0 after release, and no stale sample is presented.

Configuration
REQ-027 With macro DESCRAMBLER_BITREV_EN defined, lane k of beat c SHALL be written to address bitrev8(8*c + k), so a bit-reversed-order FFT result drains in natural order.
REQ-028 Without DESCRAMBLER_BITREV_EN, the write address SHALL be 8*c + k (identity order). The read side is identical in both builds.

Structure
REQ-029 Package fft_pkg SHALL hold DW, LANES, NPTS, the beat-count constant, and the complex sample typedef {re, im}; it is shared with the scrambler-side blocks.
REQ-030 The 8-bit bit-reversal SHALL be a combinational sub-module fft_bitrev, instantiated only when DESCRAMBLER_BITREV_EN is defined.

Verification
REQ-031 Reset then identity build: send 32 beats, lane k of beat c = {re = 8c+k, im = ~(8c+k)}, out_ready = 1. Expect:
- out_valid one cycle after the last beat.
- 256 samples with out_data.re = out_idx.
- frame_done after index 255.
- in_ready back to 1.
REQ-032 BITREV build, same stimulus. Expect out_idx = 1 -> re = 128, out_idx = 2 -> re = 64, out_idx = 255 -> re = 255.
REQ-033 Random out_ready backpressure (50%). Expect out_data and out_idx stable while stalled, all 256 samples delivered exactly once, in order.
REQ-034 Drive in_valid = 1 continuously through DRAIN with changing data. Expect in_ready = 0 and drained data unchanged from the captured frame.
REQ-035 Assert rst_n low after beat 17 and again at out_idx = 100. Expect all outputs at reset values, and the next full frame to collect and drain correctly from beat 0.
REQ-036 Send two back-to-back frames with in_valid gapped randomly. Expect the second frame's data only, with c wrap and out_idx wrap correct.
